fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//   Drives the instruction-memory address every cycle and holds the PC register.
//   Captures each combinational instruction read into a small FIFO and hands it to decode over a valid/ready handshake.
//   Handles control-flow redirects (flush plus reload), halt and out-of-range fault.
//   Sits between the PC/branch logic and the 128-word instruction memory.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC loaded on reset
//   FIFO_DEPTH  2              fetch buffer entries (power of 2, >=2)
//   IMEM_WORDS  128            instruction memory size in words; valid byte range 0..IMEM_WORDS*4-1
// PORTS
//   Clk             in   1   clock, rising edge
//   Reset           in   1   synchronous, active-high reset
//   ImemAddress     out  32  byte address to instruction memory (= FetchPC, combinational)
//   ImemInstruction in   32  instruction word read at ImemAddress (same cycle)
//   Redirect        in   1   load new PC and flush buffer (branch/jump resolved)
//   RedirectTarget  in   32  new PC; bits [1:0] forced to 0
//   Halt            in   1   level: suspend fetching, buffer still drains
//   OutValid        out  1   buffer head valid
//   OutReady        in   1   decode accepts head
//   OutInstruction  out 32   head instruction
//   OutPC           out 32   head PC
//   OutPCPlus4      out 32   head PC + 4
//   Fault           out  1   high while in FAULT state
// BEHAVIOUR
//   Reset (sync, priority over everything):
//     FetchPC=RESET_PC; FIFO empty; state=FETCH.
//     OutValid=0, OutInstruction/OutPC/OutPCPlus4=0, Fault=0.
//   States:
//     FETCH  -> HALTED when Halt=1 (evaluated before push; no push that cycle)
//     FETCH  -> FAULT  when FetchPC >= IMEM_WORDS*4 (no push)
//     HALTED -> FETCH  when Halt=0
//     FAULT  -> FETCH  only on Redirect with in-range target, or Reset
//   Push: state FETCH, in range, !Redirect, and (count<FIFO_DEPTH or pop this cycle).
//     Writes {FetchPC, ImemInstruction}; FetchPC += 4 (32-bit wrap, then range check).
//     No push -> FetchPC holds.
//   Pop: OutValid & OutReady; head advances.
//     Simultaneous push+pop keeps count unchanged, including when full.
//   Latency: word at FetchPC=A is visible on Out* at the next edge if FIFO was empty.
//     Sustained throughput is 1 instr/cycle while OutReady=1.
//   Redirect (priority over push/pop; any state except reset):
//     FIFO cleared next cycle (OutValid=0).
//     FetchPC = {RedirectTarget[31:2],2'b00}.
//     A handshake in the same cycle counts as accepted.
//     From FAULT: in-range target -> FETCH, out-of-range target -> stays FAULT.
//     From HALTED: PC updates, stays HALTED while Halt=1.
//   Halt: never discards buffered entries; decode may keep popping.
//   Out* hold stable while OutValid=1 and OutReady=0.
//   Out* are undefined-but-stable (hold last) when OutValid=0; the bench checks them only when valid.
//   OutPCPlus4 = OutPC + 4, 32-bit wrap.
// TESTING
//   1. Reset, OutReady=1, imem[i]=i*4:
//      -> from cycle 2, OutPC=0,4,8,... with OutInstruction==OutPC, one per cycle, no gaps.
//   2. OutReady=0 for 5 cycles:
//      -> FIFO fills to 2 entries and FetchPC freezes at 8.
//      -> OutPC holds 0; on release, 0,4,8 in order with no loss or duplicate.
//   3. Redirect=1, RedirectTarget=32'h13 while 2 entries buffered:
//      -> next cycle OutValid=0, FetchPC=0x10; following cycle OutPC=0x10.
//   4. Run to PC=0x1FC with IMEM_WORDS=128:
//      -> 0x1FC delivered, then Fault=1 and no further pushes.
//      -> Redirect to 0x00 clears Fault and fetch restarts at 0.
//   5. Halt=1 with 2 entries buffered and OutReady=1:
//      -> both entries drain, FetchPC constant, then OutValid=0.
//      -> Halt=0 resumes at the held PC.
//   6. Reset asserted mid-stream with OutValid=1:
//      -> next cycle OutValid=0, FetchPC=RESET_PC, Fault=0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer, instruction memory, redirect/halt
// control and the decode-side valid/ready handshake.
interface fetch_sequencer_if;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic        Halt;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutInstruction;
    logic [31:0] OutPC;
    logic [31:0] OutPCPlus4;
    logic        Fault;

    // Sequencer side
    modport slave (
        output ImemAddress, OutValid, OutInstruction, OutPC, OutPCPlus4, Fault,
        input  ImemInstruction, Redirect, RedirectTarget, Halt, OutReady
    );

    // Environment side (memory, branch logic, decode)
    modport master (
        input  ImemAddress, OutValid, OutInstruction, OutPC, OutPCPlus4, Fault,
        output ImemInstruction, Redirect, RedirectTarget, Halt, OutReady
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC, drives the instruction-memory address,
// buffers {PC, instruction} pairs in a small FIFO for decode, and handles
// redirect (flush + reload), halt and out-of-range fault.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          IMEM_WORDS = 128
) (
    input  logic             Clk,
    input  logic             Reset,
    fetch_sequencer_if.slave bus
);
    localparam int               PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W      = PTR_W + 1;
    localparam logic [32:0]      IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Buffer storage; PC+4 is stored so it reads back as zero after reset.
    logic [31:0] pc_mem_q    [FIFO_DEPTH];
    logic [31:0] pc4_mem_q   [FIFO_DEPTH];
    logic [31:0] instr_mem_q [FIFO_DEPTH];

    logic [31:0] target_pc;
    logic        pc_in_range;
    logic        target_in_range;
    logic        out_valid;
    logic        pop;
    logic        push;

    // Redirect targets are always word aligned.
    assign target_pc       = bus.RedirectTarget & 32'hFFFF_FFFC;
    // 33-bit compare so a full 32-bit memory size cannot overflow the bound.
    assign pc_in_range     = {1'b0, fetch_pc_q} < IMEM_BYTES;
    assign target_in_range = {1'b0, target_pc} < IMEM_BYTES;
    assign out_valid       = (count_q != '0);
    assign pop             = out_valid & bus.OutReady;
    // Halt and range are judged before the push, and a full buffer may
    // still accept a word when the head leaves in the same cycle.
    assign push            = (state_q == ST_FETCH) && pc_in_range && !bus.Redirect &&
                             !bus.Halt && ((count_q != FULL_COUNT) || pop);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: halt wins in FETCH, fault only left via an in-range redirect
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (bus.Halt) begin
                    state_d = ST_HALTED;
                end else if (!bus.Redirect && !pc_in_range) begin
                    state_d = ST_FAULT;
                end
            end
            ST_HALTED: begin
                if (!bus.Halt) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FAULT: begin
                if (bus.Redirect && target_in_range) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.Fault = (state_q == ST_FAULT);
    end

    // Next PC and buffer bookkeeping; a redirect flushes and overrides push/pop
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (bus.Redirect) begin
            fetch_pc_d = target_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // PC and buffer pointer registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            // Capture the word being fetched into the slot at the write pointer
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    pc_mem_q[gi]    <= '0;
                    pc4_mem_q[gi]   <= '0;
                    instr_mem_q[gi] <= '0;
                end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    pc_mem_q[gi]    <= fetch_pc_q;
                    pc4_mem_q[gi]   <= fetch_pc_q + 32'd4;
                    instr_mem_q[gi] <= bus.ImemInstruction;
                end
            end
        end
    endgenerate

    assign bus.ImemAddress    = fetch_pc_q;
    assign bus.OutValid       = out_valid;
    assign bus.OutPC          = pc_mem_q[rd_ptr_q];
    assign bus.OutPCPlus4     = pc4_mem_q[rd_ptr_q];
    assign bus.OutInstruction = instr_mem_q[rd_ptr_q];
endmodule
